serial_frame_rx: RTL and testbench

Downstream consumer of the enable-gated flop stage (`clk`, `en`, `rst_n`, `data_in` -> `data_out`). It takes that stage's registered serial bit stream plus its bit-valid enable and hunts for a sync word. Once locked, it deserialises fixed-width frames into parallel words, each with a one-cycle valid pulse. Optionally it checks an even-parity bit per frame.

---
 rtl/serial_rx_pkg.sv | 20 ++
 rtl/serial_frame_rx_sync_window.sv | 44 ++++
 rtl/serial_frame_rx.sv | 139 +++++++++++++
 tb/tb_serial_frame_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and defaults for the serial frame receiver.
// SERIAL_RX_PARITY_EN adds one trailing even-parity bit to every frame.
package serial_rx_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } rx_state_t;

    localparam int          DEF_DATA_W    = 8;
    localparam int          DEF_SYNC_W    = 8;
    localparam logic [7:0]  DEF_SYNC_WORD = 8'hA5;

`ifdef SERIAL_RX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/serial_frame_rx_sync_window.sv
// Sliding sync-word window with saturating fill count; o_match already
// includes the bit being sampled on the current edge.
module sync_window
    import serial_rx_pkg::*;
#(
    parameter int                SYNC_W    = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(DEF_SYNC_WORD)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_shift,
    input  logic i_clear,
    input  logic i_bit,
    output logic o_match
);

    localparam int                FILL_W    = $clog2(SYNC_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_W);

    logic [SYNC_W-1:0] r_win;
    logic [FILL_W-1:0] r_fill;
    logic [SYNC_W-1:0] w_win_next;

    function automatic logic [FILL_W-1:0] sat_inc(input logic [FILL_W-1:0] v);
        return (v == FILL_FULL) ? v : v + 1'b1;
    endfunction

    assign w_win_next = {r_win[SYNC_W-2:0], i_bit};
    assign o_match    = (sat_inc(r_fill) == FILL_FULL) && (w_win_next == SYNC_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_win  <= w_win_next;
            r_fill <= sat_inc(r_fill);
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for SYNC_WORD, then deserialises back-to-back
// DATA_W-bit frames. SERIAL_RX_PARITY_EN enables a per-frame even-parity check.
module serial_frame_rx
    import serial_rx_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                SYNC_W    = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(DEF_SYNC_WORD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              data_in,
    input  logic              resync,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              synced,
    output logic              parity_err
);

    localparam int                FRAME_LEN = DATA_W + PARITY_BITS;
    localparam int                BCNT_W    = $clog2(DATA_W + 2);
    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(FRAME_LEN - 1);
    localparam logic [BCNT_W-1:0] PAY_BITS  = BCNT_W'(DATA_W);

    rx_state_t         r_state, w_state_next;
    logic [BCNT_W-1:0] r_bcnt, w_bcnt_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data_out;
    logic [DATA_W-1:0] w_payload;
    logic              r_data_valid;
    logic              w_complete;
    logic              w_win_shift;
    logic              w_win_clear;
    logic              w_match;

`ifdef SERIAL_RX_PARITY_EN
    logic r_parity_err;
    logic w_parity_bad;
    // The last sampled bit is the parity bit; the payload is already in r_shift.
    assign w_parity_bad = ^{r_shift, data_in};
    assign w_payload    = r_shift;
`else
    assign w_payload    = {r_shift[DATA_W-2:0], data_in};
`endif

    sync_window #(
        .SYNC_W    (SYNC_W),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync_window (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_shift (w_win_shift),
        .i_clear (w_win_clear),
        .i_bit   (data_in),
        .o_match (w_match)
    );

    always_comb begin
        w_state_next = r_state;
        w_bcnt_next  = r_bcnt;
        w_complete   = 1'b0;
        w_win_shift  = 1'b0;
        w_win_clear  = 1'b0;
        if (resync) begin
            w_state_next = HUNT;
            w_bcnt_next  = '0;
            w_win_clear  = 1'b1;
        end else if (en) begin
            case (r_state)
                HUNT: begin
                    w_win_shift = 1'b1;
                    // Window is emptied on lock so any later hunt needs a full fresh sync word.
                    if (w_match) begin
                        w_state_next = COLLECT;
                        w_bcnt_next  = '0;
                        w_win_clear  = 1'b1;
                    end
                end
                COLLECT: begin
                    if (r_bcnt == LAST_BIT) begin
                        w_complete  = 1'b1;
                        w_bcnt_next = '0;
`ifdef SERIAL_RX_PARITY_EN
                        if (w_parity_bad) begin
                            w_state_next = HUNT;
                        end
`endif
                    end else begin
                        w_bcnt_next = r_bcnt + 1'b1;
                    end
                end
                default: w_state_next = HUNT;
            endcase
        end
    end

    // ---- control / output register stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= HUNT;
            r_bcnt       <= '0;
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_bcnt       <= w_bcnt_next;
            r_data_valid <= w_complete;
            if (w_complete) begin
                r_data_out <= w_payload;
            end
        end
    end

    // Payload shifter carries no reset: it is only read once a full frame is in.
    always_ff @(posedge clk) begin
        if (en && !resync && (r_state == COLLECT) && (r_bcnt < PAY_BITS)) begin
            r_shift <= {r_shift[DATA_W-2:0], data_in};
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_complete & w_parity_bad;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign synced     = (r_state == COLLECT);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed scenarios plus random bit streams,
// checked every cycle against a behavioural bit-history model.
module tb_serial_frame_rx;

    localparam int         DATA_W = 8;
    localparam int         SYNC_W = 8;
    localparam logic [7:0] SYNC   = 8'hA5;
`ifdef SERIAL_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              data_in;
    logic              resync;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              synced;
    logic              parity_err;

    int n_total = 0;
    int n_bad   = 0;
    bit cmp_en  = 0;

    serial_frame_rx #(
        .DATA_W    (DATA_W),
        .SYNC_W    (SYNC_W),
        .SYNC_WORD (SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data_in    (data_in),
        .resync     (resync),
        .data_out   (data_out),
        .data_valid (data_valid),
        .synced     (synced),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: keeps the raw bit history while hunting and the
    // received frame bits while locked, and decides outputs from those.
    int          m_locked = 0;
    int          m_fill   = 0;
    int          m_cnt    = 0;
    logic [31:0] m_hist   = '0;
    logic [63:0] m_frame  = '0;
    logic [7:0]  e_dout   = '0;
    bit          e_dv     = 0;
    bit          e_perr   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_locked = 0; m_fill = 0; m_cnt = 0; m_hist = '0; m_frame = '0;
            e_dout = '0; e_dv = 0; e_perr = 0;
        end else begin
            e_dv   = 0;
            e_perr = 0;
            if (resync) begin
                m_locked = 0; m_fill = 0; m_cnt = 0; m_hist = '0; m_frame = '0;
            end else if (en) begin
                if (m_locked == 0) begin
                    m_hist = {m_hist[30:0], data_in};
                    if (m_fill < SYNC_W) m_fill++;
                    if (m_fill == SYNC_W && m_hist[SYNC_W-1:0] == SYNC) begin
                        m_locked = 1; m_cnt = 0; m_frame = '0; m_fill = 0; m_hist = '0;
                    end
                end else begin
                    m_frame = {m_frame[62:0], data_in};
                    m_cnt++;
                    if (m_cnt == DATA_W + PB) begin
                        e_dv   = 1;
                        e_dout = 8'(m_frame >> PB);
                        if (PB == 1 && (^m_frame[DATA_W:0])) begin
                            e_perr   = 1;
                            m_locked = 0;
                        end
                        m_cnt = 0; m_frame = '0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_data_out",   32'(data_out),   32'(e_dout));
            check("cyc_data_valid", 32'(data_valid), 32'(e_dv));
            check("cyc_synced",     32'(synced),     32'(m_locked != 0));
            check("cyc_parity_err", 32'(parity_err), 32'(e_perr));
        end
    end

    task automatic bit_cycle(input logic b, input logic e, input logic rs);
        data_in = b;
        en      = e;
        resync  = rs;
        @(posedge clk);
        #1;
        en     = 1'b0;
        resync = 1'b0;
    endtask

    // gap 0: dense, 1: one idle cycle before each bit, 2: 0..2 random idle cycles
    task automatic send_bits(input logic [31:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            if (gap == 1) bit_cycle(1'($urandom), 1'b0, 1'b0);
            if (gap == 2) begin
                int k;
                k = $urandom_range(0, 2);
                for (int j = 0; j < k; j++) bit_cycle(1'($urandom), 1'b0, 1'b0);
            end
            bit_cycle(v[i], 1'b1, 1'b0);
        end
    endtask

    task automatic send_payload(input logic [7:0] v, input int gap);
        send_bits(32'(v), DATA_W, gap);
        if (PB == 1) send_bits(32'(^v), 1, gap);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; data_in = 1'b0; resync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out",   32'(data_out),   32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_synced",     32'(synced),     32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        rst_n  = 1'b1;
        cmp_en = 1;

        // Dense lock then one frame
        send_bits(32'hA5, 8, 0);
        check("t1_synced", 32'(synced), 32'h1);
        send_payload(8'h3C, 0);
        check("t1_valid", 32'(data_valid), 32'h1);
        check("t1_data",  32'(data_out),   32'h3C);
        bit_cycle(1'b0, 1'b1, 1'b0);
        check("t1_valid_1cyc", 32'(data_valid), 32'h0);
        bit_cycle(1'b0, 1'b0, 1'b1);
        check("t1_resync", 32'(synced), 32'h0);

        // Sparse enable
        send_bits(32'hA5, 8, 1);
        check("t2_synced", 32'(synced), 32'h1);
        send_payload(8'h3C, 1);
        check("t2_valid", 32'(data_valid), 32'h1);
        check("t2_data",  32'(data_out),   32'h3C);
        bit_cycle(1'b1, 1'b0, 1'b0);
        check("t2_valid_1cyc", 32'(data_valid), 32'h0);
        check("t2_data_hold",  32'(data_out),   32'h3C);

        // Back-to-back frames
        send_payload(8'h01, 0);
        check("t3_data0", 32'(data_out), 32'h01);
        send_payload(8'hFF, 0);
        check("t3_valid1", 32'(data_valid), 32'h1);
        check("t3_data1",  32'(data_out),   32'hFF);

        // Resync on the 4th payload bit, then relock
        send_bits(32'h5, 3, 0);
        bit_cycle(1'b1, 1'b1, 1'b1);
        check("t4_synced", 32'(synced),     32'h0);
        check("t4_valid",  32'(data_valid), 32'h0);
        send_bits(32'hA5, 8, 0);
        check("t4_relock", 32'(synced), 32'h1);

`ifdef SERIAL_RX_PARITY_EN
        send_bits(32'h03, 8, 0);
        send_bits(32'h1, 1, 0);
        check("t5_perr",   32'(parity_err), 32'h1);
        check("t5_data",   32'(data_out),   32'h03);
        check("t5_synced", 32'(synced),     32'h0);
        send_bits(32'hA5, 8, 0);
        send_bits(32'h03, 8, 0);
        send_bits(32'h0, 1, 0);
        check("t5_ok_perr",   32'(parity_err), 32'h0);
        check("t5_ok_valid",  32'(data_valid), 32'h1);
        check("t5_ok_synced", 32'(synced),     32'h1);
`endif

        // Asynchronous reset mid-frame, then an incomplete sync word
        send_payload(8'h96, 0);
        send_bits(32'h3, 3, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_data_out",   32'(data_out),   32'h0);
        check("t6_data_valid", 32'(data_valid), 32'h0);
        check("t6_synced",     32'(synced),     32'h0);
        check("t6_parity_err", 32'(parity_err), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_bits(32'hA5 >> 1, 7, 0);
        check("t6_7bits", 32'(synced), 32'h0);
        bit_cycle(1'b1, 1'b1, 1'b0);
        check("t6_8bits", 32'(synced), 32'h1);

        // Random traffic
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 15) begin
                send_bits(32'hA5, 8, 2);
            end else if (r < 80) begin
                send_payload(8'($urandom), 2);
            end else if (r < 95) begin
                send_bits($urandom, $urandom_range(1, 5), 2);
            end else begin
                bit_cycle(1'($urandom), 1'($urandom), 1'b1);
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
